// File: rtl/lif_layer_tm.sv
// Layer of leaky integrate-and-fire neurons sharing one datapath.
// Each timestep updates the neurons in index order, one per clock.
module lif_layer_tm #(
    parameter int N_INPUTS      = 32,
    parameter int N_NEURONS     = 4,
    parameter int MEMBRANE_BITS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   data_in,
    input  logic [2:0]                   cfg_sel,
    input  logic                         cfg_strobe,
    input  logic                         start,
    input  logic [$clog2(N_NEURONS)-1:0] mon_sel,
    output logic                         busy,
    output logic                         done,
    output logic [N_NEURONS-1:0]         spikes,
    output logic [MEMBRANE_BITS-1:0]     membrane_out
);
    localparam int SW   = $clog2(N_NEURONS);
    localparam int MB   = MEMBRANE_BITS;
    localparam int NW   = N_NEURONS * N_INPUTS;
    localparam int SUMW = $clog2(N_INPUTS) + 2;
    localparam int CW   = MB + 2;
    localparam logic signed [CW-1:0] C_MAX = CW'((2 ** (MB - 1)) - 1);
    localparam logic signed [CW-1:0] C_MIN = CW'(-(2 ** (MB - 1)));

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SW-1:0]          r_idx;
    logic [N_INPUTS-1:0]    r_inputs;
    logic [NW-1:0]          r_weights;
    logic [MB-2:0]          r_thresh;
    logic [2:0]             r_leak;
    logic [3:0]             r_refr;
    logic signed [MB-1:0]   r_mem [N_NEURONS];
    logic [3:0]             r_cnt [N_NEURONS];
    logic [N_NEURONS-1:0]   r_spikes;

    logic                   w_cfg_we;
    logic [N_INPUTS-1:0]    w_wsel;
    logic signed [SUMW-1:0] w_sum;
    logic signed [MB-1:0]   w_mcur;
    logic signed [MB-1:0]   w_leaked;
    logic signed [CW-1:0]   w_cand;
    logic signed [MB-1:0]   w_sat;
    logic signed [MB-1:0]   w_thr;
    logic                   w_fire;
    logic signed [MB-1:0]   w_mem_pad [2**SW];

    // Configuration is frozen for the whole timestep.
    assign w_cfg_we = cfg_strobe & (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inputs  <= '0;
            r_weights <= '1;
            r_thresh  <= (MB - 1)'(5);
            r_leak    <= '0;
            r_refr    <= '0;
        end else if (w_cfg_we) begin
            case (cfg_sel)
                3'd0: r_inputs  <= (r_inputs << 8) | N_INPUTS'(data_in);
                3'd1: r_weights <= (r_weights << 8) | NW'(data_in);
                3'd2: r_thresh  <= (r_thresh << 8) | (MB - 1)'(data_in);
                3'd3: r_leak    <= data_in[2:0];
                3'd4: r_refr    <= data_in[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_UPDATE;
            S_UPDATE: if (r_idx == SW'(N_NEURONS - 1)) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_idx <= '0;
        else if (r_state == S_UPDATE) r_idx <= r_idx + 1'b1;
        else                         r_idx <= '0;
    end

    assign w_wsel = r_weights[r_idx * N_INPUTS +: N_INPUTS];

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (r_inputs[i]) begin
                if (w_wsel[i]) w_sum = w_sum + SUMW'(1);
                else           w_sum = w_sum - SUMW'(1);
            end
        end
    end

    // A zero leak shift means no leak, not a full discharge.
    assign w_mcur   = r_mem[r_idx];
    assign w_leaked = (r_leak == 3'd0) ? w_mcur : w_mcur - (w_mcur >>> r_leak);
    assign w_cand   = CW'(w_leaked) + CW'(w_sum);

    always_comb begin
        w_sat = w_cand[MB-1:0];
        if (w_cand > C_MAX)      w_sat = {1'b0, {(MB - 1){1'b1}}};
        else if (w_cand < C_MIN) w_sat = {1'b1, {(MB - 1){1'b0}}};
    end

    assign w_thr  = $signed({1'b0, r_thresh});
    assign w_fire = (w_sat >= w_thr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_NEURONS; j++) begin
                r_mem[j] <= '0;
                r_cnt[j] <= '0;
            end
            r_spikes <= '0;
        end else if (r_state == S_UPDATE) begin
            if (r_cnt[r_idx] != 4'd0) begin
                r_cnt[r_idx]    <= r_cnt[r_idx] - 4'd1;
                r_mem[r_idx]    <= '0;
                r_spikes[r_idx] <= 1'b0;
            end else if (w_fire) begin
                r_cnt[r_idx]    <= r_refr;
                r_mem[r_idx]    <= '0;
                r_spikes[r_idx] <= 1'b1;
            end else begin
                r_mem[r_idx]    <= w_sat;
                r_spikes[r_idx] <= 1'b0;
            end
        end
    end

    assign spikes = r_spikes;

    genvar k;
    generate
        for (k = 0; k < 2**SW; k++) begin : g_pad
            if (k < N_NEURONS) begin : g_real
                assign w_mem_pad[k] = r_mem[k];
            end else begin : g_zero
                assign w_mem_pad[k] = '0;
            end
        end
    endgenerate

    assign membrane_out = w_mem_pad[mon_sel];

endmodule

// File: tb/tb_lif_layer_tm.sv
// Bench for lif_layer_tm: fixed vectors, directed sequences and a
// randomized run against an arithmetic model of the neuron layer.
module tb_lif_layer_tm;
    localparam int NI = 32;
    localparam int NN = 4;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    data_in = '0;
    logic [2:0]    cfg_sel = '0;
    logic          cfg_strobe = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mon_sel = '0;
    logic          busy;
    logic          done;
    logic [NN-1:0] spikes;
    logic [MB-1:0] membrane_out;

    lif_layer_tm #(
        .N_INPUTS(NI), .N_NEURONS(NN), .MEMBRANE_BITS(MB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .cfg_sel(cfg_sel),
        .cfg_strobe(cfg_strobe), .start(start), .mon_sel(mon_sel),
        .busy(busy), .done(done), .spikes(spikes),
        .membrane_out(membrane_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [NI-1:0]    m_in;
    logic [NN*NI-1:0] m_w;
    int               m_thr, m_leak, m_refr;
    int               m_mem [NN];
    int               m_cnt [NN];
    logic [NN-1:0]    m_spk;

    typedef struct {
        logic [31:0] in;
        logic [7:0]  thr;
        int          mem;
        logic [3:0]  spk;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int floor_div(input int m, input int k);
        int d, q;
        d = 1 << k;
        q = m / d;
        if ((m % d) != 0 && m < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        m_in = '0;
        m_w = '1;
        m_thr = 5;
        m_leak = 0;
        m_refr = 0;
        m_spk = '0;
        for (int j = 0; j < NN; j++) begin
            m_mem[j] = 0;
            m_cnt[j] = 0;
        end
    endtask

    task automatic model_run();
        logic [NI-1:0] wj;
        int sum, lk, c;
        for (int j = 0; j < NN; j++) begin
            wj = m_w[j*NI +: NI];
            sum = $countones(m_in & wj) - $countones(m_in & ~wj);
            if (m_cnt[j] > 0) begin
                m_cnt[j]--;
                m_mem[j] = 0;
                m_spk[j] = 1'b0;
            end else begin
                lk = (m_leak == 0) ? m_mem[j]
                                   : m_mem[j] - floor_div(m_mem[j], m_leak);
                c = lk + sum;
                if (c > 127) c = 127;
                if (c < -128) c = -128;
                if (c >= m_thr) begin
                    m_spk[j] = 1'b1;
                    m_mem[j] = 0;
                    m_cnt[j] = m_refr;
                end else begin
                    m_spk[j] = 1'b0;
                    m_mem[j] = c;
                end
            end
        end
    endtask

    task automatic cfg(input logic [2:0] sel, input logic [7:0] d);
        @(negedge clk);
        cfg_sel = sel;
        data_in = d;
        cfg_strobe = 1'b1;
        @(negedge clk);
        cfg_strobe = 1'b0;
        case (sel)
            3'd0: m_in = (m_in << 8) | NI'(d);
            3'd1: m_w = (m_w << 8) | (NN*NI)'(d);
            3'd2: m_thr = int'(d) % 128;
            3'd3: m_leak = int'(d) % 8;
            3'd4: m_refr = int'(d) % 16;
            default: ;
        endcase
    endtask

    task automatic load_inputs(input logic [31:0] v);
        for (int b = 3; b >= 0; b--) cfg(3'd0, v[b*8 +: 8]);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic run_step(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(tag);
        model_run();
    endtask

    task automatic check_const(input string tag, input int mem,
                               input logic [3:0] spk);
        for (int j = 0; j < NN; j++) begin
            mon_sel = 2'(j);
            #1;
            check($sformatf("%s_mem%0d", tag, j), $signed(membrane_out), mem);
        end
        check({tag, "_spikes"}, spikes, spk);
    endtask

    task automatic check_model(input string tag);
        for (int j = 0; j < NN; j++) begin
            mon_sel = 2'(j);
            #1;
            check($sformatf("%s_mem%0d", tag, j), $signed(membrane_out), m_mem[j]);
        end
        check({tag, "_spikes"}, spikes, m_spk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_spikes", spikes, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_0003, 8'd5,   2,  4'h0};
        vecs[1] = '{32'h0000_000F, 8'd5,   4,  4'h0};
        vecs[2] = '{32'h0000_001F, 8'd5,   0,  4'hF};
        vecs[3] = '{32'h0000_001F, 8'd6,   5,  4'h0};
        vecs[4] = '{32'h0000_0000, 8'd0,   0,  4'hF};
        vecs[5] = '{32'hFFFF_FFFF, 8'd127, 32, 4'h0};
        vecs[6] = '{32'h0000_001F, 8'h85,  0,  4'hF};
        vecs[7] = '{32'h8000_0001, 8'h83,  2,  4'h0};
        model_reset();

        reset_dut();
        check_const("reset", 0, 4'h0);

        load_inputs(32'hFFFF_FFFF);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("timing_busy_c%0d", c), busy, 1);
            check($sformatf("timing_done_c%0d", c), done, (c == 5) ? 1 : 0);
            @(negedge clk);
        end
        check("timing_busy_after", busy, 0);
        check("timing_done_after", done, 0);
        check_const("timing", 0, 4'hF);

        for (int v = 0; v < 8; v++) begin
            reset_dut();
            load_inputs(vecs[v].in);
            cfg(3'd2, vecs[v].thr);
            run_step($sformatf("vec%0d", v));
            check_const($sformatf("vec%0d", v), vecs[v].mem, vecs[v].spk);
        end

        reset_dut();
        load_inputs(32'h0000_0003);
        run_step("integ1");
        check_const("integ1", 2, 4'h0);
        run_step("integ2");
        check_const("integ2", 4, 4'h0);
        run_step("integ3");
        check_const("integ3", 0, 4'hF);

        reset_dut();
        for (int b = 0; b < 16; b++) cfg(3'd1, 8'h00);
        load_inputs(32'hFFFF_FFFF);
        for (int r = 0; r < 5; r++) begin
            run_step($sformatf("sat%0d", r));
            check_const($sformatf("sat%0d", r), (r < 4) ? -32 * (r + 1) : -128, 4'h0);
        end

        reset_dut();
        cfg(3'd3, 8'd1);
        load_inputs(32'h0000_000F);
        run_step("leak0");
        check_const("leak0", 4, 4'h0);
        load_inputs(32'h0);
        run_step("leak1");
        check_const("leak1", 2, 4'h0);
        run_step("leak2");
        check_const("leak2", 1, 4'h0);
        run_step("leak3");
        check_const("leak3", 1, 4'h0);

        reset_dut();
        cfg(3'd4, 8'd2);
        load_inputs(32'hFFFF_FFFF);
        run_step("refr1");
        check_const("refr1", 0, 4'hF);
        run_step("refr2");
        check_const("refr2", 0, 4'h0);
        run_step("refr3");
        check_const("refr3", 0, 4'h0);
        run_step("refr4");
        check_const("refr4", 0, 4'hF);

        reset_dut();
        cfg(3'd2, 8'd9);
        cfg(3'd3, 8'd2);
        load_inputs(32'h0000_001F);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        mon_sel = 2'd0;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_spikes", spikes, 0);
        check("abort_mem0", $signed(membrane_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        model_reset();
        @(negedge clk);
        start = 1'b0;
        check("abort_restart_busy", busy, 1);
        wait_done("abort_run0");
        check_const("abort_run0", 0, 4'h0);
        load_inputs(32'h0000_001F);
        run_step("abort_thr");
        check_const("abort_thr", 0, 4'hF);

        reset_dut();
        load_inputs(32'h0000_0003);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        cfg_sel = 3'd2;
        data_in = 8'd0;
        cfg_strobe = 1'b1;
        @(negedge clk);
        cfg_strobe = 1'b0;
        start = 1'b0;
        wait_done("ignore");
        check_const("ignore", 2, 4'h0);
        @(negedge clk);
        check("ignore_idle1", busy, 0);
        @(negedge clk);
        check("ignore_idle2", busy, 0);
        run_step("ignore_next");
        check_const("ignore_next", 4, 4'h0);

        reset_dut();
        for (int e = 0; e < 6; e++) begin
            for (int b = 0; b < 16; b++) cfg(3'd1, 8'($urandom));
            for (int b = 0; b < 4; b++)
                cfg(3'd0, 8'($urandom) & 8'($urandom));
            cfg(3'd2, 8'($urandom_range(0, 30)));
            cfg(3'd3, 8'($urandom));
            cfg(3'd4, 8'($urandom_range(0, 3)));
            for (int r = 0; r < 5; r++) begin
                run_step($sformatf("rnd%0d_%0d", e, r));
                check_model($sformatf("rnd%0d_%0d", e, r));
                if (r[0]) cfg(3'd0, 8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
